// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 streaming convolution engine.
package conv_pkg;

    localparam int unsigned KTAPS = 9;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Result width: full product width plus headroom for a nine-term sum.
    function automatic int unsigned out_w(input int unsigned data_w);
        return 2 * data_w + 4;
    endfunction

endpackage

// File: rtl/conv3x3_line_buffer.sv
// Two row delay lines plus a 3x3 sliding window over a raster-order pixel stream.
module conv3x3_line_buffer
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W  = 6,
    parameter int unsigned DATA_W = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push_i,
    input  logic                          win_ok_i,
    input  logic [DATA_W-1:0]             pix_i,
    output logic [KTAPS-1:0][DATA_W-1:0]  win_o,
    output logic                          win_valid_o
);

    logic [IMG_W-1:0][DATA_W-1:0] lb0_q;
    logic [IMG_W-1:0][DATA_W-1:0] lb1_q;
    logic [2:0][2:0][DATA_W-1:0]  win_q;
    logic                         win_valid_q;

    // Shift the row delay lines and the window on every accepted pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lb0_q       <= '0;
            lb1_q       <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
        end else begin
            win_valid_q <= push_i & win_ok_i;
            if (push_i) begin
                lb0_q <= {lb0_q[IMG_W-2:0], pix_i};
                lb1_q <= {lb1_q[IMG_W-2:0], lb0_q[IMG_W-1]};
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= lb1_q[IMG_W-1];
                win_q[1][2] <= lb0_q[IMG_W-1];
                win_q[2][2] <= pix_i;
            end
        end
    end

    // Tap k = row*3 + col, row 0 is the oldest line, col 0 the leftmost pixel.
    assign win_o       = win_q;
    assign win_valid_o = win_valid_q;

endmodule

// File: rtl/conv3x3_stream_pipelined.sv
// Streaming 3x3 convolution: kernel load, raster counters, window, multiply and sum stages.
module conv3x3_stream_pipelined
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IMG_W  = 6,
    parameter int unsigned IMG_H  = 6,
    parameter bit          SIGNED = 1'b0,
    parameter int unsigned OUT_W  = out_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              weight_valid,
    input  logic [DATA_W-1:0] In_Weight_1,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] In_IFM_1,
    output logic              out_valid,
    output logic [OUT_W-1:0]  Out_OFM,
    output logic              busy
);

    localparam int unsigned PW    = 2 * DATA_W;
    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned WC_W  = $clog2(KTAPS);

    state_e                       state_q, state_d;
    logic [COL_W-1:0]             col_q, col_d;
    logic [ROW_W-1:0]             row_q, row_d;
    logic [WC_W-1:0]              wcnt_q, wcnt_d;
    logic [KTAPS-1:0][DATA_W-1:0] w_q;
    logic                         busy_q, busy_d;
    logic                         accept_c, w_we_c, win_ok_c;

    logic [KTAPS-1:0][DATA_W-1:0] win;
    logic                         win_valid;
    logic [KTAPS-1:0][DATA_W-1:0] s1_win_q;
    logic                         s1_v_q;
    logic [KTAPS-1:0][PW-1:0]     prod_q, prod_d;
    logic                         s2_v_q;
    logic [OUT_W-1:0]             sum_c;
    logic [OUT_W-1:0]             out_q;
    logic                         out_v_q;

    // Operand extension to product width according to the arithmetic mode.
    function automatic logic [PW-1:0] ext_op(input logic [DATA_W-1:0] x);
        return {{DATA_W{SIGNED & x[DATA_W-1]}}, x};
    endfunction

    // Next state, raster counters, kernel write strobe and busy.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        wcnt_d   = wcnt_q;
        w_we_c   = 1'b0;
        accept_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept_c = 1'b1;
                    state_d  = RUN;
                    wcnt_d   = '0;
                end else if (weight_valid) begin
                    w_we_c = 1'b1;
                    wcnt_d = (wcnt_q == WC_W'(KTAPS - 1)) ? '0 : wcnt_q + WC_W'(1);
                end
            end
            RUN:     accept_c = in_valid;
            default: state_d  = IDLE;
        endcase
        if (accept_c) begin
            if (col_q == COL_W'(IMG_W - 1)) begin
                col_d = '0;
                if (row_q == ROW_W'(IMG_H - 1)) begin
                    row_d   = '0;
                    state_d = IDLE;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
        win_ok_c = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
        busy_d   = (state_d == RUN) | (accept_c & win_ok_c) | win_valid | s1_v_q | s2_v_q;
    end

    // Control registers: FSM state, counters, kernel, busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            wcnt_q  <= '0;
            w_q     <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            wcnt_q  <= wcnt_d;
            busy_q  <= busy_d;
            if (w_we_c) begin
                w_q[wcnt_q] <= In_Weight_1;
            end
        end
    end

    conv3x3_line_buffer #(
        .IMG_W  (IMG_W),
        .DATA_W (DATA_W)
    ) u_lb (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (accept_c),
        .win_ok_i    (win_ok_c),
        .pix_i       (In_IFM_1),
        .win_o       (win),
        .win_valid_o (win_valid)
    );

    // Nine products against the current kernel, and the sum of the registered products.
    always_comb begin
        prod_d = '0;
        sum_c  = '0;
        for (int unsigned k = 0; k < KTAPS; k++) begin
            prod_d[k] = ext_op(s1_win_q[k]) * ext_op(w_q[k]);
            sum_c     = sum_c + {{(OUT_W - PW){SIGNED & prod_q[k][PW-1]}}, prod_q[k]};
        end
    end

    // S1 window capture, S2 product registers, S3 output register; never stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_win_q <= '0;
            s1_v_q   <= 1'b0;
            prod_q   <= '0;
            s2_v_q   <= 1'b0;
            out_q    <= '0;
            out_v_q  <= 1'b0;
        end else begin
            s1_v_q  <= win_valid;
            s2_v_q  <= s1_v_q;
            out_v_q <= s2_v_q;
            if (win_valid) begin
                s1_win_q <= win;
            end
            if (s1_v_q) begin
                prod_q <= prod_d;
            end
            out_q <= s2_v_q ? sum_c : '0;
        end
    end

    assign out_valid = out_v_q;
    assign Out_OFM   = out_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_conv3x3_stream_pipelined.sv
// Randomised bench for conv3x3_stream_pipelined: unsigned and signed instances share stimulus.
module tb_conv3x3_stream_pipelined;

    localparam int W = 6;
    localparam int H = 6;
    localparam int N = W * H;
    localparam longint MASK36 = 64'h0000_000F_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n, weight_valid, in_valid;
    logic [15:0] In_Weight_1, In_IFM_1;
    logic        ov_u, ov_s, busy_u, busy_s;
    logic [35:0] ofm_u, ofm_s;

    always #5 clk = ~clk;

    conv3x3_stream_pipelined #(.DATA_W(16), .IMG_W(W), .IMG_H(H), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .weight_valid(weight_valid), .In_Weight_1(In_Weight_1),
        .in_valid(in_valid), .In_IFM_1(In_IFM_1), .out_valid(ov_u), .Out_OFM(ofm_u), .busy(busy_u));

    conv3x3_stream_pipelined #(.DATA_W(16), .IMG_W(W), .IMG_H(H), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .weight_valid(weight_valid), .In_Weight_1(In_Weight_1),
        .in_valid(in_valid), .In_IFM_1(In_IFM_1), .out_valid(ov_s), .Out_OFM(ofm_s), .busy(busy_s));

    typedef struct {
        int     due;
        longint vu;
        longint vs;
    } exp_t;

    exp_t        q[$];
    longint      cap_u[$];
    longint      cap_s[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          started = 1'b0;
    bit          running = 1'b0;
    int          pos = 0;
    int          wcnt = 0;
    logic [15:0] wts[9];
    logic [15:0] img[H][W];
    logic [15:0] wbuf[9];
    logic [15:0] pconst;
    int          p14_cyc = 0;
    int          first_ov = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: image held as a 2D array, each result computed directly from the kernel.
    initial begin
        foreach (wts[i]) wts[i] = '0;
        forever begin
            @(posedge clk);
            cyc++;
            started = 1'b1;
            if (!rst_n) begin
                running = 1'b0;
                pos     = 0;
                wcnt    = 0;
                foreach (wts[i]) wts[i] = '0;
                q.delete();
            end else begin
                if (!running && weight_valid && !in_valid) begin
                    wts[wcnt] = In_Weight_1;
                    wcnt      = (wcnt + 1) % 9;
                end else if (!running && in_valid) begin
                    wcnt = 0;
                end
                if (in_valid) begin
                    int r, c;
                    r = pos / W;
                    c = pos % W;
                    img[r][c] = In_IFM_1;
                    if (pos == 14) p14_cyc = cyc;
                    if (r >= 2 && c >= 2) begin
                        longint su, ss;
                        exp_t   e;
                        su = 0;
                        ss = 0;
                        for (int dr = 0; dr < 3; dr++) begin
                            for (int dc = 0; dc < 3; dc++) begin
                                logic [15:0] px, wt;
                                px = img[r-2+dr][c-2+dc];
                                wt = wts[dr*3+dc];
                                su += longint'(px) * longint'(wt);
                                ss += longint'($signed(px)) * longint'($signed(wt));
                            end
                        end
                        e.due = cyc + 3;
                        e.vu  = su;
                        e.vs  = ss & MASK36;
                        q.push_back(e);
                    end
                    pos++;
                    if (pos == N) begin
                        pos     = 0;
                        running = 1'b0;
                    end else begin
                        running = 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                bit   ev, eb;
                exp_t e;
                ev = (q.size() > 0) && (q[0].due == cyc);
                eb = running || (q.size() > 0);
                e.due = 0;
                e.vu  = 0;
                e.vs  = 0;
                if (ev) e = q[0];
                chk("out_valid_u", 64'(ov_u), 64'(ev));
                chk("out_valid_s", 64'(ov_s), 64'(ev));
                chk("ofm_u", 64'(ofm_u), 64'(e.vu));
                chk("ofm_s", 64'(ofm_s), 64'(e.vs));
                chk("busy_u", 64'(busy_u), 64'(eb));
                chk("busy_s", 64'(busy_s), 64'(eb));
                if (ov_u === 1'b1) begin
                    if (cap_u.size() == 0) first_ov = cyc;
                    cap_u.push_back(longint'(ofm_u));
                    cap_s.push_back(longint'(ofm_s));
                end
                if (ev) void'(q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic drive(input logic rst, input logic wv, input logic [15:0] w,
                         input logic iv, input logic [15:0] px);
        @(negedge clk);
        rst_n        = rst;
        weight_valid = wv;
        In_Weight_1  = w;
        in_valid     = iv;
        In_IFM_1     = px;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    endtask

    task automatic load_wbuf();
        for (int i = 0; i < 9; i++) drive(1'b1, 1'b1, wbuf[i], 1'b0, 16'h0);
    endtask

    task automatic rand_wbuf();
        for (int i = 0; i < 9; i++) wbuf[i] = 16'($urandom);
    endtask

    // mode 0: pixel = index, 1: pconst, 2: random. gap 0: none, 1: every other cycle, 2: random.
    task automatic run_image(input int mode, input int gap, input bit noise, input int rst_at);
        for (int i = 0; i < N; i++) begin
            logic [15:0] px;
            int ng;
            ng = 0;
            if (i > 0 && gap == 1) ng = 1;
            if (i > 0 && gap == 2) ng = $urandom_range(0, 2);
            repeat (ng) drive(1'b1, noise, 16'd7, 1'b0, 16'h0);
            px = (mode == 0) ? 16'(i) : (mode == 1) ? pconst : 16'($urandom);
            if (i == rst_at) begin
                drive(1'b0, 1'b0, 16'h0, 1'b1, px);
                return;
            end
            drive(1'b1, 1'b0, 16'h0, 1'b1, px);
        end
    endtask

    task automatic clear_caps();
        cap_u.delete();
        cap_s.delete();
        first_ov = -1;
    endtask

    task automatic check_ramp(input string tag);
        chk({tag, "_count"}, 64'(cap_u.size()), 64'd16);
        for (int k = 0; k < cap_u.size() && k < 16; k++)
            chk({tag, "_val"}, 64'(cap_u[k]), 64'(9 * ((k / 4 + 1) * 6 + k % 4 + 1)));
        chk({tag, "_latency"}, 64'(first_ov - p14_cyc), 64'd3);
    endtask

    initial begin
        rst_n        = 1'b0;
        weight_valid = 1'b0;
        In_Weight_1  = '0;
        in_valid     = 1'b0;
        In_IFM_1     = '0;
        repeat (3) drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        idle(2);

        // All-ones kernel over a 0..35 ramp, continuous then with alternating gaps and weight noise.
        foreach (wbuf[i]) wbuf[i] = 16'd1;
        load_wbuf();
        clear_caps();
        run_image(0, 0, 1'b0, -1);
        idle(6);
        check_ramp("ramp");
        chk("ramp_first", 64'(cap_u.size() > 0 ? cap_u[0] : -1), 64'd63);
        clear_caps();
        run_image(0, 1, 1'b1, -1);
        idle(6);
        check_ramp("ramp_gap");

        // Signed extreme: (-1) * (-32768) summed nine times.
        foreach (wbuf[i]) wbuf[i] = 16'hFFFF;
        load_wbuf();
        pconst = 16'h8000;
        clear_caps();
        run_image(1, 0, 1'b0, -1);
        idle(6);
        chk("signed_count", 64'(cap_s.size()), 64'd16);
        foreach (cap_s[k]) chk("signed_val", 64'(cap_s[k]), 64'd294912);

        // Unsigned extreme: 0xFFFF * 0xFFFF summed nine times.
        pconst = 16'hFFFF;
        clear_caps();
        run_image(1, 0, 1'b0, -1);
        idle(6);
        chk("unsigned_count", 64'(cap_u.size()), 64'd16);
        foreach (cap_u[k]) chk("unsigned_val", 64'(cap_u[k]), 64'd38653526025);

        // Random kernel, two images back-to-back.
        rand_wbuf();
        load_wbuf();
        clear_caps();
        run_image(2, 0, 1'b0, -1);
        run_image(2, 0, 1'b0, -1);
        idle(6);
        chk("b2b_count", 64'(cap_u.size()), 64'd32);

        // Random kernel, random gaps with weight beats during the image.
        rand_wbuf();
        load_wbuf();
        clear_caps();
        run_image(2, 2, 1'b1, -1);
        idle(6);
        chk("gap_count", 64'(cap_u.size()), 64'd16);

        // Reset mid-image, then reload and rerun.
        rand_wbuf();
        load_wbuf();
        run_image(2, 0, 1'b0, 20);
        idle(1);
        chk("rst_out_valid", 64'(ov_u), 64'd0);
        chk("rst_busy", 64'(busy_u), 64'd0);
        rand_wbuf();
        load_wbuf();
        clear_caps();
        run_image(2, 1, 1'b0, -1);
        idle(6);
        chk("rerun_count", 64'(cap_u.size()), 64'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
